// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared types and defaults for the ALU reservation station.
// Optional feature macro used by alu_rs: ALU_RS_DISPATCH_BYPASS_EN.
package alu_rs_pkg;

    localparam int RS_DEPTH_DEF = 4;
    localparam int RS_TAG_W_DEF = 4;

    // Tags are stored zero-extended to this width so one record type serves
    // every TAG_W up to this limit.
    localparam int RS_TAG_MAX_W = 16;

    typedef logic [RS_TAG_MAX_W-1:0] rs_tag_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rs1_rdy;
        logic [31:0] rs1_val;
        rs_tag_t     rs1_tag;
        logic        rs2_rdy;
        logic [31:0] rs2_val;
        rs_tag_t     rs2_tag;
        rs_tag_t     dst_tag;
    } rs_entry_t;

    // True when a waiting operand is satisfied by the current broadcast.
    function automatic logic tag_hit(input logic    rdy,
                                     input rs_tag_t tag,
                                     input logic    cdb_v,
                                     input rs_tag_t cdb_tag);
        return !rdy && cdb_v && (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// alu_rs_pick: priority encoder returning the lowest set index of a ready vector.
module alu_rs_pick
    import alu_rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH_DEF,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] i_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest (oldest) ready index wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: collapsing-queue reservation station feeding one ALU.
// Entries stay in allocation order (index 0 oldest); the oldest entry whose
// operands were ready at the start of the cycle issues one cycle later.
// Optional feature: define ALU_RS_DISPATCH_BYPASS_EN to let a dispatching
// operand capture a same-cycle CDB broadcast for its tag.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH_DEF,
    parameter int TAG_W = RS_TAG_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             dispatch_valid_i,
    output logic             dispatch_ready_o,
    input  logic [31:0]      dispatch_pc_i,
    input  logic [31:0]      dispatch_inst_i,
    input  logic             dispatch_rs1_rdy_i,
    input  logic             dispatch_rs2_rdy_i,
    input  logic [31:0]      dispatch_rs1_val_i,
    input  logic [31:0]      dispatch_rs2_val_i,
    input  logic [TAG_W-1:0] dispatch_rs1_tag_i,
    input  logic [TAG_W-1:0] dispatch_rs2_tag_i,
    input  logic [TAG_W-1:0] dispatch_dst_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [31:0]      cdb_value_i,
    input  logic             flush_i,
    output logic             alu_request_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic [31:0]      rs1_value_o,
    output logic [31:0]      rs2_value_o,
    output logic [TAG_W-1:0] dst_tag_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t        r_entry [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic             r_alu_req;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic [31:0]      r_rs1_val;
    logic [31:0]      r_rs2_val;
    logic [TAG_W-1:0] r_dst_tag;

    logic [DEPTH-1:0] w_ready_vec;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic             w_issue;
    logic             w_dispatch;
    rs_tag_t          w_cdb_tag;
    rs_entry_t        w_woke [DEPTH+1];
    rs_entry_t        w_next [DEPTH];
    rs_entry_t        w_new;
    rs_entry_t        w_sel;
    logic [CNT_W-1:0] w_count_rm;
    logic [CNT_W-1:0] w_count_next;

    assign dispatch_ready_o = (r_count != CNT_W'(DEPTH));
    assign w_cdb_tag        = rs_tag_t'(cdb_tag_i);
    assign w_issue          = w_pick_found & ~flush_i;
    assign w_dispatch       = dispatch_valid_i & dispatch_ready_o & ~flush_i;
    assign w_sel            = r_entry[w_pick_idx];

    // Issue candidates are judged on registered state, before this cycle's wakeup.
    always_comb begin
        w_ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ready_vec[i] = r_entry[i].valid & r_entry[i].rs1_rdy & r_entry[i].rs2_rdy;
        end
    end

    alu_rs_pick #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_ready (w_ready_vec),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // CDB wakeup of every waiting operand; the extra slot feeds the collapse shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woke[i] = r_entry[i];
            if (r_entry[i].valid &&
                tag_hit(r_entry[i].rs1_rdy, r_entry[i].rs1_tag, cdb_valid_i, w_cdb_tag)) begin
                w_woke[i].rs1_rdy = 1'b1;
                w_woke[i].rs1_val = cdb_value_i;
            end
            if (r_entry[i].valid &&
                tag_hit(r_entry[i].rs2_rdy, r_entry[i].rs2_tag, cdb_valid_i, w_cdb_tag)) begin
                w_woke[i].rs2_rdy = 1'b1;
                w_woke[i].rs2_val = cdb_value_i;
            end
        end
        w_woke[DEPTH] = '0;
    end

    // Build the record for an incoming dispatch.
    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.pc      = dispatch_pc_i;
        w_new.inst    = dispatch_inst_i;
        w_new.rs1_rdy = dispatch_rs1_rdy_i;
        w_new.rs1_val = dispatch_rs1_val_i;
        w_new.rs1_tag = rs_tag_t'(dispatch_rs1_tag_i);
        w_new.rs2_rdy = dispatch_rs2_rdy_i;
        w_new.rs2_val = dispatch_rs2_val_i;
        w_new.rs2_tag = rs_tag_t'(dispatch_rs2_tag_i);
        w_new.dst_tag = rs_tag_t'(dispatch_dst_tag_i);
`ifdef ALU_RS_DISPATCH_BYPASS_EN
        if (tag_hit(w_new.rs1_rdy, w_new.rs1_tag, cdb_valid_i, w_cdb_tag)) begin
            w_new.rs1_rdy = 1'b1;
            w_new.rs1_val = cdb_value_i;
        end
        if (tag_hit(w_new.rs2_rdy, w_new.rs2_tag, cdb_valid_i, w_cdb_tag)) begin
            w_new.rs2_rdy = 1'b1;
            w_new.rs2_val = cdb_value_i;
        end
`endif
    end

    // Collapse out the issued entry first, then append the dispatch at the new tail.
    always_comb begin
        w_count_rm   = r_count - CNT_W'(w_issue);
        w_count_next = w_count_rm + CNT_W'(w_dispatch);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && (i >= int'(w_pick_idx))) begin
                w_next[i] = w_woke[i+1];
            end else begin
                w_next[i] = w_woke[i];
            end
            if (w_dispatch && (i == int'(w_count_rm))) begin
                w_next[i] = w_new;
            end
        end
    end

    // Queue storage and occupancy; flush empties the station.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_next[i];
            end
            r_count <= w_count_next;
        end
    end

    // Issue registers: request pulses for one cycle, data holds its last value.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_alu_req <= 1'b0;
            r_pc      <= '0;
            r_inst    <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_dst_tag <= '0;
        end else begin
            r_alu_req <= w_issue;
            if (w_issue) begin
                r_pc      <= w_sel.pc;
                r_inst    <= w_sel.inst;
                r_rs1_val <= w_sel.rs1_val;
                r_rs2_val <= w_sel.rs2_val;
                r_dst_tag <= w_sel.dst_tag[TAG_W-1:0];
            end
        end
    end

    assign alu_request_o = r_alu_req;
    assign pc_o          = r_pc;
    assign inst_o        = r_inst;
    assign rs1_value_o   = r_rs1_val;
    assign rs2_value_o   = r_rs2_val;
    assign dst_tag_o     = r_dst_tag;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed-vector bench for the ALU reservation station.
module tb_alu_rs;

    logic        clk_i;
    logic        reset_i;
    logic        dispatch_valid_i;
    logic        dispatch_ready_o;
    logic [31:0] dispatch_pc_i;
    logic [31:0] dispatch_inst_i;
    logic        dispatch_rs1_rdy_i;
    logic        dispatch_rs2_rdy_i;
    logic [31:0] dispatch_rs1_val_i;
    logic [31:0] dispatch_rs2_val_i;
    logic [3:0]  dispatch_rs1_tag_i;
    logic [3:0]  dispatch_rs2_tag_i;
    logic [3:0]  dispatch_dst_tag_i;
    logic        cdb_valid_i;
    logic [3:0]  cdb_tag_i;
    logic [31:0] cdb_value_i;
    logic        flush_i;
    logic        alu_request_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [31:0] rs1_value_o;
    logic [31:0] rs2_value_o;
    logic [3:0]  dst_tag_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs #(.DEPTH(4), .TAG_W(4)) u_dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .dispatch_valid_i   (dispatch_valid_i),
        .dispatch_ready_o   (dispatch_ready_o),
        .dispatch_pc_i      (dispatch_pc_i),
        .dispatch_inst_i    (dispatch_inst_i),
        .dispatch_rs1_rdy_i (dispatch_rs1_rdy_i),
        .dispatch_rs2_rdy_i (dispatch_rs2_rdy_i),
        .dispatch_rs1_val_i (dispatch_rs1_val_i),
        .dispatch_rs2_val_i (dispatch_rs2_val_i),
        .dispatch_rs1_tag_i (dispatch_rs1_tag_i),
        .dispatch_rs2_tag_i (dispatch_rs2_tag_i),
        .dispatch_dst_tag_i (dispatch_dst_tag_i),
        .cdb_valid_i        (cdb_valid_i),
        .cdb_tag_i          (cdb_tag_i),
        .cdb_value_i        (cdb_value_i),
        .flush_i            (flush_i),
        .alu_request_o      (alu_request_o),
        .pc_o               (pc_o),
        .inst_o             (inst_o),
        .rs1_value_o        (rs1_value_o),
        .rs2_value_o        (rs2_value_o),
        .dst_tag_o          (dst_tag_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        dispatch_valid_i   = 1'b0;
        dispatch_pc_i      = '0;
        dispatch_inst_i    = '0;
        dispatch_rs1_rdy_i = 1'b0;
        dispatch_rs2_rdy_i = 1'b0;
        dispatch_rs1_val_i = '0;
        dispatch_rs2_val_i = '0;
        dispatch_rs1_tag_i = '0;
        dispatch_rs2_tag_i = '0;
        dispatch_dst_tag_i = '0;
        cdb_valid_i        = 1'b0;
        cdb_tag_i          = '0;
        cdb_value_i        = '0;
        flush_i            = 1'b0;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] inst,
                        input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                        input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag,
                        input logic [3:0] dst);
        dispatch_valid_i   = 1'b1;
        dispatch_pc_i      = pc;
        dispatch_inst_i    = inst;
        dispatch_rs1_rdy_i = r1rdy;
        dispatch_rs1_val_i = r1val;
        dispatch_rs1_tag_i = r1tag;
        dispatch_rs2_rdy_i = r2rdy;
        dispatch_rs2_val_i = r2val;
        dispatch_rs2_tag_i = r2tag;
        dispatch_dst_tag_i = dst;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid_i = 1'b1;
        cdb_tag_i   = tag;
        cdb_value_i = val;
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req",   32'(alu_request_o),    32'd0);
        chk("rst_ready", 32'(dispatch_ready_o), 32'd1);
        chk("rst_pc",    pc_o,                  32'd0);
        chk("rst_inst",  inst_o,                32'd0);
        chk("rst_rs1",   rs1_value_o,           32'd0);
        chk("rst_rs2",   rs2_value_o,           32'd0);
        chk("rst_dst",   32'(dst_tag_o),        32'd0);
        reset_i = 1'b0;

        // ADDI x1,x0,5 with both operands ready issues on the second edge.
        disp(32'h100, 32'h0050_0093, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 4'd1);
        tick(); idle();
        chk("addi_req_early", 32'(alu_request_o), 32'd0);
        tick();
        chk("addi_req",  32'(alu_request_o), 32'd1);
        chk("addi_rs1",  rs1_value_o,        32'd5);
        chk("addi_inst", inst_o,             32'h0050_0093);
        chk("addi_pc",   pc_o,               32'h100);
        chk("addi_dst",  32'(dst_tag_o),     32'd1);
        tick();
        chk("addi_req_drop", 32'(alu_request_o),    32'd0);
        chk("addi_ready",    32'(dispatch_ready_o), 32'd1);
        chk("addi_hold_rs1", rs1_value_o,           32'd5);

        // Back-to-back: issue and dispatch in the same cycle.
        disp(32'h200, 32'h0020_8133, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd2);
        tick();
        disp(32'h204, 32'h4011_01b3, 1'b1, 32'd9, 4'd0, 1'b1, 32'd1, 4'd0, 4'd3);
        tick(); idle();
        chk("b2b_req0", 32'(alu_request_o), 32'd1);
        chk("b2b_pc0",  pc_o,               32'h200);
        chk("b2b_rs2",  rs2_value_o,        32'd4);
        tick();
        chk("b2b_req1", 32'(alu_request_o), 32'd1);
        chk("b2b_pc1",  pc_o,               32'h204);
        chk("b2b_dst1", 32'(dst_tag_o),     32'd3);
        tick();
        chk("b2b_done", 32'(alu_request_o), 32'd0);

        // rs1 waits on tag 3; broadcast arrives two cycles after dispatch.
        disp(32'h300, 32'h0001_8213, 1'b0, 32'd0, 4'd3, 1'b1, 32'd7, 4'd0, 4'd4);
        tick(); idle();
        tick();
        chk("wake_wait", 32'(alu_request_o), 32'd0);
        cdb(4'd3, 32'h10);
        tick(); idle();
        chk("wake_cdb_cycle", 32'(alu_request_o), 32'd0);
        tick();
        chk("wake_req", 32'(alu_request_o), 32'd1);
        chk("wake_rs1", rs1_value_o,        32'h10);
        chk("wake_rs2", rs2_value_o,        32'd7);
        chk("wake_dst", 32'(dst_tag_o),     32'd4);
        tick();
        chk("wake_done", 32'(alu_request_o), 32'd0);

        // Fill the station with waiting entries (tags 8..11).
        for (int k = 0; k < 4; k++) begin
            disp(32'h400 + 32'(4 * k), 32'h13, 1'b0, 32'd0, 4'(8 + k),
                 1'b1, 32'(k), 4'd0, 4'(5 + k));
            tick();
        end
        idle();
        chk("full_ready", 32'(dispatch_ready_o), 32'd0);
        disp(32'h500, 32'h13, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd15);
        tick(); idle();
        chk("full_no_issue", 32'(alu_request_o),    32'd0);
        chk("full_ready2",   32'(dispatch_ready_o), 32'd0);
        cdb(4'd10, 32'h22);
        tick(); idle();
        chk("e2_wake_req",   32'(alu_request_o),    32'd0);
        chk("e2_wake_ready", 32'(dispatch_ready_o), 32'd0);
        tick();
        chk("e2_req",   32'(alu_request_o),    32'd1);
        chk("e2_pc",    pc_o,                  32'h408);
        chk("e2_rs1",   rs1_value_o,           32'h22);
        chk("e2_rs2",   rs2_value_o,           32'd2);
        chk("e2_dst",   32'(dst_tag_o),        32'd7);
        chk("e2_ready", 32'(dispatch_ready_o), 32'd1);
        cdb(4'd8, 32'h33);
        tick(); idle();
        chk("drop_overflow", 32'(alu_request_o), 32'd0);

        // Flush with a ready entry and a concurrent dispatch.
        flush_i = 1'b1;
        disp(32'h600, 32'h13, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0, 4'd9);
        tick(); idle();
        chk("flush_req",   32'(alu_request_o),    32'd0);
        chk("flush_ready", 32'(dispatch_ready_o), 32'd1);
        tick();
        chk("flush_drop_disp", 32'(alu_request_o), 32'd0);
        cdb(4'd9, 32'h1);
        tick();
        cdb(4'd11, 32'h2);
        tick(); idle();
        tick();
        chk("flush_empty", 32'(alu_request_o), 32'd0);

        // Two entries woken by one broadcast issue oldest first; also proves count=0.
        disp(32'h700, 32'h13, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0, 4'd1);
        tick();
        disp(32'h704, 32'h13, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0, 4'd2);
        tick();
        disp(32'h708, 32'h13, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 4'd3);
        tick();
        chk("three_ready", 32'(dispatch_ready_o), 32'd1);
        disp(32'h70c, 32'h13, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 4'd4);
        tick(); idle();
        chk("four_ready", 32'(dispatch_ready_o), 32'd0);
        cdb(4'd5, 32'h44);
        tick(); idle();
        chk("pair_wake_req", 32'(alu_request_o), 32'd0);
        tick();
        chk("pair_req0", 32'(alu_request_o), 32'd1);
        chk("pair_pc0",  pc_o,               32'h700);
        chk("pair_rs10", rs1_value_o,        32'h44);
        tick();
        chk("pair_req1", 32'(alu_request_o), 32'd1);
        chk("pair_pc1",  pc_o,               32'h704);
        chk("pair_rs11", rs1_value_o,        32'h44);
        tick();
        chk("pair_done", 32'(alu_request_o), 32'd0);
        flush_i = 1'b1;
        tick(); idle();

        // Dispatch coincident with a broadcast of its own source tag.
        disp(32'h800, 32'h13, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 4'd6);
        cdb(4'd7, 32'h99);
        tick(); idle();
        tick();
`ifdef ALU_RS_DISPATCH_BYPASS_EN
        chk("byp_req", 32'(alu_request_o), 32'd1);
        chk("byp_rs1", rs1_value_o,        32'h99);
        tick();
        chk("byp_done", 32'(alu_request_o), 32'd0);
`else
        chk("nobyp_req", 32'(alu_request_o), 32'd0);
        tick();
        chk("nobyp_wait", 32'(alu_request_o), 32'd0);
        cdb(4'd7, 32'h55);
        tick(); idle();
        tick();
        chk("nobyp_late_req", 32'(alu_request_o), 32'd1);
        chk("nobyp_late_rs1", rs1_value_o,        32'h55);
`endif

        // Asynchronous reset mid-cycle clears outputs and entries at once.
        disp(32'h900, 32'h13, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0, 4'd0, 4'd2);
        tick(); idle();
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_pc",    pc_o,                  32'd0);
        chk("arst_rs1",   rs1_value_o,           32'd0);
        chk("arst_req",   32'(alu_request_o),    32'd0);
        chk("arst_ready", 32'(dispatch_ready_o), 32'd1);
        #1;
        reset_i = 1'b0;
        tick();
        cdb(4'd14, 32'h7);
        tick(); idle();
        tick();
        chk("arst_empty", 32'(alu_request_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter DEPTH, default 4: number of reservation-station entries, 2..16.
REQ-002 Parameter TAG_W, default 4: width of ROB/physical tags.
REQ-003 clk_i  input  1  single clock; all state rises on posedge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 dispatch_valid_i  input  1  dispatch offers an ALU instruction this cycle.
REQ-006 dispatch_ready_o  output  1  station accepts dispatch this cycle.
REQ-007 dispatch_pc_i, dispatch_inst_i  input  32 each  instruction PC and raw encoding.
REQ-008 dispatch_rs1_rdy_i, dispatch_rs2_rdy_i  input  1 each  operand value already valid.
REQ-009 dispatch_rs1_val_i, dispatch_rs2_val_i  input  32 each  operand values when ready.
REQ-010 dispatch_rs1_tag_i, dispatch_rs2_tag_i  input  TAG_W each  producer tags when not ready.
REQ-011 dispatch_dst_tag_i  input  TAG_W  destination tag of the instruction.
REQ-012 cdb_valid_i, cdb_tag_i, cdb_value_i  input  1/TAG_W/32  common-data-bus broadcast.
REQ-013 flush_i  input  1  discard all entries (mispredict/exception).
REQ-014 alu_request_o  output  1  issued instruction valid, drives the arithmetic unit request.
REQ-015 pc_o, inst_o, rs1_value_o, rs2_value_o  output  32 each  issued operands.
REQ-016 dst_tag_o  output  TAG_W  destination tag accompanying the issue.

Function
REQ-017 Entries SHALL be kept in allocation order (collapsing queue); index 0 is oldest.
REQ-018 dispatch_ready_o SHALL equal (count != DEPTH), from registered state only; a freed slot is usable the following cycle.
REQ-019 Dispatch SHALL occur when dispatch_valid_i && dispatch_ready_o && !flush_i; entry appended at index count.
REQ-020 Each cycle, every valid entry whose waiting operand tag equals cdb_tag_i with cdb_valid_i high SHALL capture cdb_value_i and set that operand ready; both operands may wake in the same cycle.
REQ-021 Issue selection SHALL pick the lowest-index entry with both operands ready at the start of the cycle (pre-wakeup state); at most one issue per cycle.
REQ-022 Selected entry SHALL be registered into the output registers and removed; alu_request_o high exactly the next cycle, i.e. issue latency one cycle after ready.
REQ-023 alu_request_o SHALL be low in any cycle following no selection; output data registers hold last value.
REQ-024 Simultaneous issue and dispatch: removal collapses first, new entry lands at count-1; count unchanged.
REQ-025 flush_i SHALL clear all entries and count, force alu_request_o low next cycle, and override same-cycle dispatch and issue.
REQ-026 count SHALL never exceed DEPTH nor underflow.

Reset
REQ-027 On reset_i all entry valid bits, count, and alu_request_o SHALL be 0; pc_o, inst_o, rs1_value_o, rs2_value_o, dst_tag_o SHALL be 0; dispatch_ready_o 1 after reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro ALU_RS_DISPATCH_BYPASS_EN defined: a non-ready dispatch operand whose tag matches a same-cycle CDB broadcast SHALL be stored ready with cdb_value_i.
REQ-030 Macro undefined: such an operand SHALL be stored not-ready and the broadcast missed (dispatch logic must then guarantee no such overlap).

Structure
REQ-031 Shared package SHALL hold the entry record type (valid, pc, inst, rs1/rs2 ready/value/tag, dst tag) and the default DEPTH/TAG_W constants.
REQ-032 Oldest-ready selection SHALL be a sub-module alu_rs_pick (priority encoder, DEPTH-wide ready vector -> index + found).

Verification
REQ-033 Dispatch ADDI, rs1 ready value 5 -> next cycle alu_request_o=1, rs1_value_o=5, inst_o matches, count back to 0.
REQ-034 Dispatch with rs1 tag 3 not ready; CDB tag 3 value 0x10 two cycles later -> issue one cycle after broadcast with rs1_value_o=0x10.
REQ-035 Fill 4 not-ready entries -> dispatch_ready_o=0; wake entry 2 -> it issues, ready returns 1 the following cycle.
REQ-036 Entries 0 and 1 woken by same CDB tag -> entry 0 issues first cycle, entry 1 next cycle.
REQ-037 3 entries valid, flush_i with concurrent dispatch -> count=0, no alu_request_o next cycle, dispatch dropped.
REQ-038 Dispatch tag 7 coincident with CDB tag 7 value 0x99 -> with macro issues rs value 0x99; without macro entry stays waiting.
